// File: rtl/register_bank.sv
// rtl/register_bank.sv - parametrised control/status register bank with RW, RO and W1C registers
// Single-outstanding request/response handshake; hw_set sticky bits win over same-edge clears.
module register_bank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    input  logic [DATA_WIDTH/8-1:0]        req_wstrb,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic                           resp_error,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_en_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  accept;
    logic                  resp_done;
    logic                  in_range;
    logic                  addr_ro;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [NUM_REGS-1:0]   wr_sel;

    // ready_en_q holds req_ready low for the first cycle after reset release
    assign req_ready  = ready_en_q && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign accept     = req_valid && req_ready;
    assign resp_done  = resp_valid && resp_ready;
    assign in_range   = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(NUM_REGS);

    always_comb begin
        rd_mux  = '0;
        addr_ro = 1'b0;
        wr_sel  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_WIDTH'(i)) begin
                rd_mux    = regs_q[i];
                addr_ro   = RO_MASK[i];
                wr_sel[i] = accept && req_write;
            end
        end
    end

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            byte_mask[b*8 +: 8] = {8{req_wstrb[b]}};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RESP;
            RESP:    if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Response is captured at the accept edge from pre-update register contents
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else if (accept) begin
            resp_rdata <= (!req_write && in_range) ? rd_mux : '0;
            resp_error <= !in_range || (req_write && addr_ro);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RO_MASK[i]) begin
                    regs_q[i] <= regs_q[i] | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (W1C_MASK[i]) begin
                    // OR-ing hw_set after the clear makes a same-edge set win
                    regs_q[i] <= (wr_sel[i] ? (regs_q[i] & ~(req_wdata & byte_mask)) : regs_q[i])
                                 | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (wr_sel[i]) begin
                    regs_q[i] <= (regs_q[i] & ~byte_mask) | (req_wdata & byte_mask);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - scoreboard bench for register_bank with a behavioural register model
module tb_register_bank;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 6;
    localparam logic [NR-1:0] RO  = 8'h41;
    localparam logic [NR-1:0] W1C = 8'h68;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic              resp_error;
    logic [NR*DW-1:0]  hw_set;
    logic [NR*DW-1:0]  reg_q;

    int total = 0;
    int bad   = 0;

    logic [NR-1:0] ro_m  = RO;
    logic [NR-1:0] w1c_m = W1C;
    logic [DW-1:0] m_reg [NR];
    bit            m_busy  = 1'b0;
    int            m_since = 0;
    logic [DW:0]   exp_q[$];
    bit            rand_hw  = 1'b0;
    bit            last_acc = 1'b0;

    register_bank #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO), .W1C_MASK(W1C)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .hw_set(hw_set), .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advances the model over the next rising edge, then compares the DUT at the falling edge
    task automatic tick();
        logic [DW-1:0] mask;
        logic [DW-1:0] rd;
        bit            exp_rdy, oor, ro, w1c, err;
        int            a;
        if (rand_hw) begin
            for (int i = 0; i < NR; i++) hw_set[i*DW +: DW] = $urandom & $urandom & $urandom;
        end
        last_acc = 1'b0;
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_reg[i] = '0;
            m_busy  = 1'b0;
            m_since = 0;
            exp_q.delete();
        end else begin
            exp_rdy = !m_busy && (m_since >= 1);
            if (m_busy && resp_ready) begin
                m_busy = 1'b0;
            end else if (req_valid && exp_rdy) begin
                last_acc = 1'b1;
                m_busy   = 1'b1;
                a   = int'(req_addr);
                oor = (a >= NR);
                ro  = !oor && ro_m[a];
                w1c = !oor && !ro && w1c_m[a];
                err = oor || (req_write && ro);
                rd  = (!req_write && !oor) ? m_reg[a] : '0;
                for (int b = 0; b < DW/8; b++) mask[b*8 +: 8] = req_wstrb[b] ? 8'hFF : 8'h00;
                if (req_write && !oor && !ro) begin
                    if (w1c) m_reg[a] = m_reg[a] & ~(req_wdata & mask);
                    else     m_reg[a] = (m_reg[a] & ~mask) | (req_wdata & mask);
                end
                exp_q.push_back({rd, err});
            end
            for (int i = 0; i < NR; i++) begin
                if (ro_m[i] || w1c_m[i]) m_reg[i] = m_reg[i] | hw_set[i*DW +: DW];
            end
            if (m_since < 2) m_since++;
        end
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], m_reg[i]);
        chk("req_ready", DW'(req_ready), DW'(!m_busy && (m_since >= 1)));
        chk("resp_valid", DW'(resp_valid), DW'(m_busy));
    endtask

    task automatic do_req(bit w, int a, logic [DW-1:0] d, logic [3:0] s, logic [NR*DW-1:0] hsv);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a[AW-1:0];
        req_wdata = d;
        req_wstrb = s;
        if (!rand_hw) hw_set = hsv;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        total++;
        if (!last_acc) begin
            bad++;
            $display("FAIL accept_timeout: addr %0d not accepted after %0d cycles", a, n);
        end
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        if (!rand_hw) hw_set = '0;
    endtask

    task automatic wait_resp(bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL resp_timeout: %0d responses still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got rdata %h error %b, required no response", resp_rdata, resp_error);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e[DW:1]);
                    chk("resp_error", DW'(resp_error), DW'(e[0]));
                end
            end
        end
    end

    initial begin : stimulus
        logic [NR*DW-1:0] hv;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0; hw_set = '0;
        tick();
        tick();
        chk("reset_rdata", resp_rdata, '0);
        chk("reset_error", DW'(resp_error), '0);
        reset_n = 1'b1;
        tick();
        tick();

        do_req(1'b1, 2, 32'hDEADBEEF, 4'hF, '0); wait_resp(1'b0);
        do_req(1'b0, 2, 32'h0, 4'h0, '0);        wait_resp(1'b0);
        chk("t1_reg2", reg_q[2*DW +: DW], 32'hDEADBEEF);

        do_req(1'b1, 1, 32'h11223344, 4'hF, '0); wait_resp(1'b0);
        do_req(1'b1, 1, 32'hAABBCCDD, 4'h5, '0); wait_resp(1'b0);
        chk("t2_reg1", reg_q[1*DW +: DW], 32'h11BB33DD);

        hw_set[3*DW +: DW] = 32'h0000000F;
        tick();
        hw_set = '0;
        do_req(1'b1, 3, 32'h00000003, 4'hF, '0); wait_resp(1'b0);
        chk("t3_w1c", reg_q[3*DW +: DW], 32'h0000000C);
        hv = '0;
        hv[3*DW +: DW] = 32'h00000001;
        do_req(1'b1, 3, 32'h00000001, 4'hF, hv); wait_resp(1'b0);
        chk("t3_set_wins", reg_q[3*DW +: DW], 32'h0000000D);
        do_req(1'b1, 3, 32'hFFFFFFFF, 4'h0, '0); wait_resp(1'b0);
        chk("t3_zero_strb", reg_q[3*DW +: DW], 32'h0000000D);

        do_req(1'b1, 0, 32'h12345678, 4'hF, '0); wait_resp(1'b0);
        chk("t4_ro_reg0", reg_q[0 +: DW], 32'h0);
        do_req(1'b0, NR, 32'h0, 4'h0, '0);       wait_resp(1'b0);
        do_req(1'b1, 6, 32'hFFFFFFFF, 4'hF, '0); wait_resp(1'b0);

        resp_ready = 1'b0;
        do_req(1'b0, 2, 32'h0, 4'h0, '0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_rdata_hold", resp_rdata, 32'hDEADBEEF);
        end
        resp_ready = 1'b1;
        tick();
        do_req(1'b0, 1, 32'h0, 4'h0, '0);
        wait_resp(1'b0);

        resp_ready = 1'b0;
        do_req(1'b0, 2, 32'h0, 4'h0, '0);
        tick();
        reset_n = 1'b0;
        tick();
        chk("t6_rdata", resp_rdata, '0);
        chk("t6_error", DW'(resp_error), '0);
        reset_n = 1'b1;
        tick();
        tick();

        rand_hw = 1'b1;
        for (int t = 0; t < 150; t++) begin
            resp_ready = 1'b0;
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
            do_req(1'($urandom_range(0, 1)), $urandom_range(0, NR + 1), $urandom, 4'($urandom), '0);
            wait_resp(1'b1);
        end
        rand_hw = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
Parametrised successor to the team's 4x32 register file. It holds NUM_REGS registers of DATA_WIDTH bits behind a single-outstanding valid/ready request/response handshake. Per-register attributes are RW, read-only, or write-1-to-clear with hardware-set sticky bits. Byte strobes, out-of-range error responses and a flat register-state export are included, so the block can serve as the control/status bank for peripherals.

Parameters:
DATA_WIDTH, 32, register width in bits; multiple of 8.
NUM_REGS, 8, number of registers; 2..64.
ADDR_WIDTH, 6, request address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (hardware-driven via hw_set only).
W1C_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i write-1-to-clear; RO_MASK takes precedence if both set.

Ports:
clk  in  1  clock; all logic on rising edge.
reset_n  in  1  synchronous reset, active-low.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_write  in  1  1=write, 0=read.
req_addr  in  ADDR_WIDTH  register index.
req_wdata  in  DATA_WIDTH  write data.
req_wstrb  in  DATA_WIDTH/8  byte enables for writes.
resp_valid  out  1  response valid.
resp_ready  in  1  response consumed when resp_valid && resp_ready.
resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
resp_error  out  1  1 = out-of-range address, or write to an RO register.
hw_set  in  NUM_REGS*DATA_WIDTH  per-bit sticky set for RO and W1C registers; register i uses slice [i*DATA_WIDTH +: DATA_WIDTH]; ignored for RW registers.
reg_q  out  NUM_REGS*DATA_WIDTH  current value of all registers, same slicing.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All registers go to 0.
  - State goes to IDLE.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - Reset wins over any accept, response or hw_set in the same cycle.
  - A pending response is dropped without handshake.
- First cycle after reset release: req_ready stays 0. It goes to 1 from the second cycle, registered, matching the existing ready-after-reset behaviour.
- FSM: two states.
  - IDLE: req_ready=1, resp_valid=0.
  - RESP: req_ready=0, resp_valid=1.
  - IDLE -> RESP on request accept.
  - RESP -> IDLE on resp_valid && resp_ready.
  - Back-to-back operation therefore gives one transaction per 2 cycles minimum.
- Accept edge: the operation executes. resp_rdata and resp_error are registered at this edge and held stable throughout RESP.
- Read latency: resp_valid asserts on the cycle after accept. resp_rdata is the register value before any same-edge hw_set.
- Write to an RW register: bytes with wstrb=1 take req_wdata; other bytes are unchanged.
- Write to a W1C register: for bytes with wstrb=1, bits where wdata=1 are cleared.
- Write to an RO register: no change; resp_error=1.
- req_addr >= NUM_REGS:
  - Reads return resp_rdata=0, resp_error=1.
  - Writes have no effect, resp_error=1.
- wstrb=0 write: legal no-op; resp_error=0 unless the address is RO or out of range.
- hw_set: applied every cycle in every state, including RESP, for RO and W1C registers: reg <= reg | hw_set.
- Same-edge W1C clear and hw_set on the same bit: set wins; the bit ends at 1.
- reg_q reflects register contents directly, with no added latency after the update edge.
- req_* inputs are don't-care while req_ready=0. The bench must hold them stable while req_valid=1 and not yet accepted.

Test Plan:
1. Reset, then write addr 2 data 0xDEADBEEF wstrb 0xF, then read addr 2 -> write response error=0; read resp_rdata=0xDEADBEEF, error=0; reg_q slice 2=0xDEADBEEF.
2. Partial strobe: reg 1=0x11223344, write 0xAABBCCDD wstrb 0x5 -> reg 1=0x11BB33DD.
3. W1C reg 3 (W1C_MASK bit 3): pulse hw_set slice 3=0x0000000F, write 0x00000003 -> reg 3=0x0000000C. Repeat with hw_set=0x1 on the same edge as the write -> bit 0 stays 1.
4. RO reg 0: write 0x12345678 -> resp_error=1, reg 0 unchanged. Read addr NUM_REGS (8) -> resp_rdata=0, resp_error=1.
5. Backpressure: read accepted, resp_ready=0 for 5 cycles -> resp_valid stays 1, rdata stable, req_ready=0; new req_valid not accepted until the cycle after the response handshake.
6. Reset mid-RESP: drive reset_n=0 while resp_valid=1 -> next edge resp_valid=0, all reg_q=0; req_ready=0 for the first cycle after release, 1 on the second.
